systolic_feeder: RTL

Upstream input stage of the N×N systolic matrix-multiply array built from accumulating processing elements. Loads two N×N operand matrices A and B over a valid/ready word stream into internal storage. On start, it drives the array's west edge (row lanes) and north edge (column lanes) with the diagonally skewed wavefront the array needs. It also emits a clear pulse for the array accumulators and flags completion once the last product has reached PE(N-1,N-1).

---
 rtl/systolic_feeder_if.sv | 26 ++
 rtl/systolic_feeder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/systolic_feeder_if.sv
// Operand stream, start/status handshake and edge lanes between an operand source,
// systolic_feeder and the N x N systolic array.
interface systolic_feeder_if #(
  parameter int unsigned BW = 8,
  parameter int unsigned N  = 5
);
  logic            iValid;
  logic            iReady;
  logic [BW-1:0]   iData;
  logic            iStart;
  logic            oBusy;
  logic            oDone;
  logic            oArrayClr;
  logic [N*BW-1:0] oRowData;
  logic [N*BW-1:0] oColData;

  modport master (
    output iValid, iData, iStart,
    input  iReady, oBusy, oDone, oArrayClr, oRowData, oColData
  );

  modport slave (
    input  iValid, iData, iStart,
    output iReady, oBusy, oDone, oArrayClr, oRowData, oColData
  );
endinterface

// File: rtl/systolic_feeder.sv
// Loads A and B (row-major, A first) and drives the diagonally skewed wavefront into the array.
// Define FEEDER_LOOP_EN to return to READY after DONE so the loaded matrices can be rerun.
module systolic_feeder #(
  parameter int unsigned BW = 8,
  parameter int unsigned N  = 5
) (
  input logic              clk,
  input logic              rst,
  systolic_feeder_if.slave bus
);

  localparam int unsigned NumWords = 2 * N * N;
  localparam int unsigned WAw      = $clog2(NumWords);
  localparam int unsigned FeedLen  = 3 * N - 2;
  localparam int unsigned TW       = $clog2(FeedLen + 1);

  localparam logic [WAw-1:0] WLast = WAw'(NumWords - 1);
  localparam logic [TW-1:0]  TLast = TW'(FeedLen - 1);

  typedef enum logic [2:0] {
    StLoad,
    StReady,
    StClr,
    StFeed,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WAw-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]    t_q, t_d;
  logic             accept;
  logic             wr_en;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clr_q, clr_d;
  logic [N*BW-1:0]  row_q, row_d;
  logic [N*BW-1:0]  col_q, col_d;
  logic [BW-1:0]    mem_q [NumWords];

  // ready_q is high only while in LOAD, so it also qualifies the transfer.
  assign accept = bus.iValid && ready_q && (state_q == StLoad);
  assign wr_en  = accept && !rst;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    t_d     = t_q;
    case (state_q)
      StLoad: begin
        if (accept) begin
          if (wcnt_q == WLast) begin
            wcnt_d  = '0;
            state_d = StReady;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      StReady: begin
        if (bus.iStart) begin
          state_d = StClr;
        end
      end
      StClr: begin
        t_d     = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (t_q == TLast) begin
          state_d = StDone;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDone: begin
`ifdef FEEDER_LOOP_EN
        state_d = StReady;
`else
        state_d = StLoad;
`endif
      end
      default: begin
        state_d = StLoad;
        wcnt_d  = '0;
        t_d     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in registers aligned with it.
  always_comb begin
    ready_d = (state_d == StLoad);
    busy_d  = (state_d == StClr) || (state_d == StFeed) || (state_d == StDone);
    done_d  = (state_d == StDone);
    clr_d   = (state_d == StClr);
    row_d   = '0;
    col_d   = '0;
    if (state_d == StFeed) begin
      for (int i = 0; i < int'(N); i++) begin
        // Lane i runs i cycles behind lane 0; outside its N-cycle window it carries zero.
        if ((int'(t_d) >= i) && (int'(t_d) - i < int'(N))) begin
          row_d[i*BW +: BW] = mem_q[WAw'(i * int'(N) + int'(t_d) - i)];
          col_d[i*BW +: BW] = mem_q[WAw'(int'(N * N) + (int'(t_d) - i) * int'(N) + i)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StLoad;
      wcnt_q  <= '0;
      t_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      t_q     <= t_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wcnt_q] <= bus.iData;
    end
  end

  // The source must never see a ready while reset is held.
  assign bus.iReady    = ready_q & ~rst;
  assign bus.oBusy     = busy_q;
  assign bus.oDone     = done_q;
  assign bus.oArrayClr = clr_q;
  assign bus.oRowData  = row_q;
  assign bus.oColData  = col_q;

endmodule
